// File: rtl/cpu_operand_fetch.sv
// Operand fetch: RF read, writeback bypass, busy scoreboard.
// Optional same-cycle writeback forwarding: `define OPFETCH_BYPASS_EN.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     decode-side handshake
//   in_rs1/in_rs2/in_rd   source/destination register addresses
//   in_rd_wr              instruction writes in_rd
//   in_imm, in_ctrl       passed through to execute
//   rf_addr_rd1/2         register file read addresses
//   rf_data_rd1/2         register file read data
//   wb_wr/addr/data       writeback port (same as RF write port)
//   out_valid/out_ready   execute-side handshake
//   out_rs1/2_val         resolved operands
//   out_rd, out_rd_wr     registered destination
//   out_imm, out_ctrl     registered pass-through fields
//   out_illegal           an accessed register is out of range
//
// MORE_REGISTERS=1: x1..x31, MORE_REGISTERS=0: x1..x15.
module cpu_operand_fetch #(
  parameter bit MORE_REGISTERS = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic        in_rd_wr,
  input  logic [31:0] in_imm,
  input  logic [15:0] in_ctrl,
  output logic [4:0]  rf_addr_rd1,
  output logic [4:0]  rf_addr_rd2,
  input  logic [31:0] rf_data_rd1,
  input  logic [31:0] rf_data_rd2,
  input  logic        wb_wr,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rs1_val,
  output logic [31:0] out_rs2_val,
  output logic [4:0]  out_rd,
  output logic        out_rd_wr,
  output logic [31:0] out_imm,
  output logic [15:0] out_ctrl,
  output logic        out_illegal
);

  localparam logic [31:0] BUSY_MASK =
    MORE_REGISTERS ? 32'hFFFF_FFFE : 32'h0000_FFFE;

  function automatic logic f_bad(input logic [4:0] a);
    return !MORE_REGISTERS && a[4];
  endfunction

  logic [31:0] r_busy;
  logic        r_out_valid;
  logic [31:0] r_rs1_val;
  logic [31:0] r_rs2_val;
  logic [4:0]  r_rd;
  logic        r_rd_wr;
  logic [31:0] r_imm;
  logic [15:0] r_ctrl;
  logic        r_illegal;

  logic        w_fwd_en;
  logic        w_rs1_bad;
  logic        w_rs2_bad;
  logic        w_rd_bad;
  logic        w_illegal;
  logic        w_res_rs1;
  logic        w_res_rs2;
  logic        w_res_rd;
  logic        w_hit_rs1;
  logic        w_hit_rs2;
  logic        w_hit_rd;
  logic        w_hazard;
  logic        w_ready;
  logic        w_fire;
  logic        w_set;
  logic [31:0] w_op1;
  logic [31:0] w_op2;
  logic [31:0] w_busy_nxt;

  // Forwarding only exists when the bypass path is built.  Without
  // it, a dependent instruction waits until the register file
  // itself holds the written value.
`ifdef OPFETCH_BYPASS_EN
  assign w_fwd_en = wb_wr;
`else
  assign w_fwd_en = 1'b0;
`endif

  assign rf_addr_rd1 = in_rs1;
  assign rf_addr_rd2 = in_rs2;

  assign w_rs1_bad = f_bad(in_rs1);
  assign w_rs2_bad = f_bad(in_rs2);
  assign w_rd_bad  = in_rd_wr && f_bad(in_rd);
  assign w_illegal = w_rs1_bad || w_rs2_bad || w_rd_bad;

  assign w_res_rs1 = w_fwd_en && (wb_addr == in_rs1);
  assign w_res_rs2 = w_fwd_en && (wb_addr == in_rs2);
  assign w_res_rd  = w_fwd_en && (wb_addr == in_rd);

  // Out-of-range registers never get a busy bit, so they never hit.
  assign w_hit_rs1 = (in_rs1 != 5'd0) && r_busy[in_rs1] && !w_res_rs1;
  assign w_hit_rs2 = (in_rs2 != 5'd0) && r_busy[in_rs2] && !w_res_rs2;
  assign w_hit_rd  = (in_rd != 5'd0) && r_busy[in_rd] && !w_res_rd;

  assign w_hazard = w_hit_rs1 || w_hit_rs2 || (in_rd_wr && w_hit_rd);

  // Only local state feeds ready; nothing from downstream ready
  // other than out_ready itself.
  assign w_ready  = (!r_out_valid || out_ready) && !w_hazard;
  assign in_ready = w_ready;
  assign w_fire   = in_valid && w_ready;

  always_comb begin
    w_op1 = rf_data_rd1;
    if (in_rs1 == 5'd0 || w_rs1_bad) begin
      w_op1 = '0;
    end else if (w_res_rs1) begin
      w_op1 = wb_data;
    end
  end

  always_comb begin
    w_op2 = rf_data_rd2;
    if (in_rs2 == 5'd0 || w_rs2_bad) begin
      w_op2 = '0;
    end else if (w_res_rs2) begin
      w_op2 = wb_data;
    end
  end

  assign w_set = w_fire && in_rd_wr && (in_rd != 5'd0) && !w_rd_bad;

  // Clear first, then set: a new writer of the register that is
  // retiring this cycle must stay tracked.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_wr && wb_addr != 5'd0) begin
      w_busy_nxt[wb_addr] = 1'b0;
    end
    if (w_set) begin
      w_busy_nxt[in_rd] = 1'b1;
    end
    w_busy_nxt = w_busy_nxt & BUSY_MASK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_rs1_val   <= '0;
      r_rs2_val   <= '0;
      r_rd        <= '0;
      r_rd_wr     <= 1'b0;
      r_imm       <= '0;
      r_ctrl      <= '0;
      r_illegal   <= 1'b0;
    end else if (w_fire) begin
      r_out_valid <= 1'b1;
      r_rs1_val   <= w_op1;
      r_rs2_val   <= w_op2;
      r_rd        <= in_rd;
      r_rd_wr     <= in_rd_wr;
      r_imm       <= in_imm;
      r_ctrl      <= in_ctrl;
      r_illegal   <= w_illegal;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_rs1_val = r_rs1_val;
  assign out_rs2_val = r_rs2_val;
  assign out_rd      = r_rd;
  assign out_rd_wr   = r_rd_wr;
  assign out_imm     = r_imm;
  assign out_ctrl    = r_ctrl;
  assign out_illegal = r_illegal;

endmodule

// File: tb/tb_cpu_operand_fetch.sv
// Bench for cpu_operand_fetch: directed scenarios plus random traffic.
// Two instances: index 0 has 31 registers, index 1 has 15.
module tb_cpu_operand_fetch;

`ifdef OPFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_rd_wr, wb_wr, out_ready;
  logic [4:0] in_rs1, in_rs2, in_rd, wb_addr;
  logic [31:0] in_imm, wb_data;
  logic [15:0] in_ctrl;

  logic [1:0] rdy, ov, ordwr, ill;
  logic [1:0][4:0] ra1, ra2, ord;
  logic [1:0][31:0] rd1, rd2, o1, o2, oimm;
  logic [1:0][15:0] octrl;

  logic [31:0] rf [32];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rd1[0] = rf[ra1[0]];
  assign rd2[0] = rf[ra2[0]];
  assign rd1[1] = rf[ra1[1]];
  assign rd2[1] = rf[ra2[1]];

  always @(posedge clk)
    if (wb_wr && wb_addr != 5'd0) rf[wb_addr] <= wb_data;

  cpu_operand_fetch #(.MORE_REGISTERS(1'b1)) u_big (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy[0]),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rd_wr(in_rd_wr), .in_imm(in_imm), .in_ctrl(in_ctrl),
    .rf_addr_rd1(ra1[0]), .rf_addr_rd2(ra2[0]),
    .rf_data_rd1(rd1[0]), .rf_data_rd2(rd2[0]),
    .wb_wr(wb_wr), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(ov[0]), .out_ready(out_ready),
    .out_rs1_val(o1[0]), .out_rs2_val(o2[0]),
    .out_rd(ord[0]), .out_rd_wr(ordwr[0]),
    .out_imm(oimm[0]), .out_ctrl(octrl[0]),
    .out_illegal(ill[0])
  );

  cpu_operand_fetch #(.MORE_REGISTERS(1'b0)) u_small (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy[1]),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rd_wr(in_rd_wr), .in_imm(in_imm), .in_ctrl(in_ctrl),
    .rf_addr_rd1(ra1[1]), .rf_addr_rd2(ra2[1]),
    .rf_data_rd1(rd1[1]), .rf_data_rd2(rd2[1]),
    .wb_wr(wb_wr), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(ov[1]), .out_ready(out_ready),
    .out_rs1_val(o1[1]), .out_rs2_val(o2[1]),
    .out_rd(ord[1]), .out_rd_wr(ordwr[1]),
    .out_imm(oimm[1]), .out_ctrl(octrl[1]),
    .out_illegal(ill[1])
  );

  // Reference model state, one copy per instance.
  bit          m_ov   [2];
  logic [31:0] m_o1   [2];
  logic [31:0] m_o2   [2];
  logic [4:0]  m_rd   [2];
  bit          m_rdwr [2];
  logic [31:0] m_imm  [2];
  logic [15:0] m_ctrl [2];
  bit          m_ill  [2];
  bit          m_busy [2][32];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp,
               $time);
    end
  endtask

  function automatic bit legal(int d, logic [4:0] a);
    return (d == 0) || (a < 5'd16);
  endfunction

  function automatic bit wb_hits(logic [4:0] a);
    return BYP && wb_wr && (wb_addr == a);
  endfunction

  function automatic bit hit(int d, logic [4:0] a);
    return (a != 5'd0) && m_busy[d][a] && !wb_hits(a);
  endfunction

  function automatic logic [31:0] opnd(int d, logic [4:0] a);
    if (a == 5'd0 || !legal(d, a)) return 32'h0;
    if (wb_hits(a)) return wb_data;
    return rf[a];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ov[d] = 0; m_o1[d] = '0; m_o2[d] = '0; m_rd[d] = '0;
      m_rdwr[d] = 0; m_imm[d] = '0; m_ctrl[d] = '0; m_ill[d] = 0;
      for (int r = 0; r < 32; r++) m_busy[d][r] = 0;
    end
  endtask

  task automatic step(int d);
    bit hz, r, fire;
    string s;
    s = $sformatf("[%0d]", d);
    chk({"out_valid", s}, ov[d], m_ov[d]);
    chk({"rs1_val", s}, o1[d], m_o1[d]);
    chk({"rs2_val", s}, o2[d], m_o2[d]);
    chk({"out_rd", s}, ord[d], m_rd[d]);
    chk({"out_rd_wr", s}, ordwr[d], m_rdwr[d]);
    chk({"out_imm", s}, oimm[d], m_imm[d]);
    chk({"out_ctrl", s}, octrl[d], m_ctrl[d]);
    chk({"illegal", s}, ill[d], m_ill[d]);
    chk({"rf_addr1", s}, ra1[d], in_rs1);
    chk({"rf_addr2", s}, ra2[d], in_rs2);
    hz = hit(d, in_rs1) || hit(d, in_rs2) ||
         (in_rd_wr && hit(d, in_rd));
    r = (!m_ov[d] || out_ready) && !hz;
    chk({"in_ready", s}, rdy[d], r);
    fire = in_valid && r;
    if (fire) begin
      m_ov[d] = 1;
      m_o1[d] = opnd(d, in_rs1);
      m_o2[d] = opnd(d, in_rs2);
      m_rd[d] = in_rd;
      m_rdwr[d] = in_rd_wr;
      m_imm[d] = in_imm;
      m_ctrl[d] = in_ctrl;
      m_ill[d] = !legal(d, in_rs1) || !legal(d, in_rs2) ||
                 (in_rd_wr && !legal(d, in_rd));
    end else if (m_ov[d] && out_ready) begin
      m_ov[d] = 0;
    end
    if (wb_wr && wb_addr != 5'd0) m_busy[d][wb_addr] = 0;
    if (fire && in_rd_wr && in_rd != 5'd0 && legal(d, in_rd))
      m_busy[d][in_rd] = 1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) model_reset();
    else for (int d = 0; d < 2; d++) step(d);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(logic [4:0] s1, logic [4:0] s2, logic [4:0] d,
                     logic w, logic [31:0] imm);
    in_valid = 1'b1;
    in_rs1 = s1; in_rs2 = s2; in_rd = d; in_rd_wr = w;
    in_imm = imm; in_ctrl = imm[15:0] ^ 16'hA5A5;
  endtask

  task automatic wb(logic w, logic [4:0] a, logic [31:0] v);
    wb_wr = w; wb_addr = a; wb_data = v;
  endtask

  task automatic rdy_is(string nm, logic exp);
    @(negedge clk);
    #1;
    chk(nm, rdy[0], exp);
  endtask

  task automatic wait_ready(string nm, int max);
    int n = 0;
    @(negedge clk);
    while (!rdy[0] && n < max) begin
      tick();
      @(negedge clk);
      n++;
    end
    checks++;
    if (!rdy[0]) begin
      errors++;
      $display("FAIL %s timeout actual=0 required=1", nm);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rd_wr = 0;
    in_imm = 0; in_ctrl = 0; out_ready = 1;
    wb(0, 0, 0);
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 0; rf[1] = 32'h11; rf[2] = 32'h22; rf[20] = 32'h2020;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", ov[0], 0);
    chk("rst_rs1", o1[0], 0);
    chk("rst_imm", oimm[0], 0);
    chk("rst_ill", ill[0], 0);
    rst_n = 1'b1;

    // add x5, x1, x2
    put(5'd1, 5'd2, 5'd5, 1, 32'h100);
    rdy_is("add_ready", 1);
    tick();
    chk("add_valid", ov[0], 1);
    chk("add_rs1", o1[0], 32'h11);
    chk("add_rs2", o2[0], 32'h22);

    // RAW on x5
    put(5'd5, 5'd0, 5'd6, 0, 32'h200);
    rdy_is("raw_stall1", 0);
    tick();
    rdy_is("raw_stall2", 0);
    tick();
    wb(1, 5'd5, 32'hABCD);
    rdy_is("raw_wb_cycle", BYP);
    tick();
    wb(0, 0, 0);
    if (!BYP) begin
      rdy_is("raw_after_wb", 1);
      tick();
    end
    in_valid = 0;
    chk("raw_rs1", o1[0], 32'hABCD);

    // x0 never busy, reads zero
    put(5'd0, 5'd0, 5'd0, 1, 32'h300);
    wb(1, 5'd0, 32'h55);
    rdy_is("x0_ready", 1);
    tick();
    wb(0, 0, 0);
    rdy_is("x0_again", 1);
    tick();
    in_valid = 0;
    chk("x0_rs1", o1[0], 0);
    chk("x0_rs2", o2[0], 0);

    // back-pressure
    put(5'd1, 5'd2, 5'd0, 0, 32'h1234);
    rdy_is("bp_first", 1);
    tick();
    out_ready = 0;
    put(5'd2, 5'd1, 5'd0, 0, 32'h5678);
    for (int i = 0; i < 3; i++) begin
      rdy_is("bp_stall", 0);
      tick();
      chk("bp_hold_rs1", o1[0], 32'h11);
      chk("bp_hold_imm", oimm[0], 32'h1234);
    end
    out_ready = 1;
    rdy_is("bp_release", 1);
    tick();
    in_valid = 0;
    chk("bp_next_rs1", o1[0], 32'h22);
    chk("bp_next_imm", oimm[0], 32'h5678);

    // same-cycle set and clear on x7
    put(5'd0, 5'd0, 5'd7, 1, 32'h700);
    rdy_is("x7_first", 1);
    tick();
    rdy_is("x7_waw", 0);
    tick();
    wb(1, 5'd7, 32'h77);
    rdy_is("x7_wb_cycle", BYP);
    tick();
    wb(0, 0, 0);
    if (!BYP) begin
      rdy_is("x7_after_wb", 1);
      tick();
    end
    put(5'd7, 5'd0, 5'd0, 0, 32'h701);
    rdy_is("x7_still_busy", 0);
    tick();
    wb(1, 5'd7, 32'h78);
    tick();
    wb(0, 0, 0);
    wait_ready("x7_drain", 10);
    tick();
    in_valid = 0;

    // out-of-range source on the 15-register instance
    put(5'd20, 5'd1, 5'd0, 0, 32'h2000);
    @(negedge clk);
    #1;
    chk("ill_ready", rdy[1], 1);
    tick();
    in_valid = 0;
    chk("ill_valid", ov[1], 1);
    chk("ill_flag", ill[1], 1);
    chk("ill_rs1", o1[1], 0);
    chk("ill_rs2", o2[1], 32'h11);
    chk("big_legal", ill[0], 0);
    chk("big_rs1", o1[0], 32'h2020);

    // async reset mid-stall
    put(5'd0, 5'd0, 5'd3, 1, 32'h3000);
    rdy_is("rst_pre", 1);
    tick();
    in_valid = 0;
    out_ready = 0;
    #2;
    chk("pre_rst_valid", ov[0], 1);
    rst_n = 0;
    #1;
    chk("async_valid", ov[0], 0);
    chk("async_valid_s", ov[1], 0);
    chk("async_rd", ord[0], 0);
    tick();
    rst_n = 1;
    out_ready = 1;
    put(5'd3, 5'd0, 5'd0, 0, 32'h3001);
    rdy_is("busy_cleared", 1);
    tick();
    in_valid = 0;

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_rs1 = ($urandom_range(0, 4) != 0) ?
               5'($urandom_range(0, 7)) : 5'($urandom);
      in_rs2 = ($urandom_range(0, 4) != 0) ?
               5'($urandom_range(0, 7)) : 5'($urandom);
      in_rd = ($urandom_range(0, 4) != 0) ?
              5'($urandom_range(0, 7)) : 5'($urandom);
      in_rd_wr = $urandom_range(0, 1);
      in_imm = $urandom;
      in_ctrl = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      wb_wr = ($urandom_range(0, 9) < 4);
      wb_addr = ($urandom_range(0, 1) != 0) ?
                5'($urandom_range(1, 7)) : 5'($urandom);
      wb_data = $urandom;
      tick();
    end
    in_valid = 0;
    wb(0, 0, 0);
    tick();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_operand_fetch.md
Name: cpu_operand_fetch

Overview:
- Operand-fetch stage between decode and execute in the CPU pipeline.
- Drives the register file's two read addresses, captures both operands into a registered output stage, and forwards same-cycle writeback data.
- Keeps a per-register busy scoreboard that stalls decode on RAW/WAW hazards against outstanding writes.
- Valid/ready handshake on both sides.

Parameters:
- MORE_REGISTERS, 1'b1: 1 gives 31 architectural registers x1..x31; 0 gives 15 registers x1..x15. With 0, any address with bit 4 set is illegal.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  decoded instruction present
- in_ready  output  1  stage accepts instruction this cycle
- in_rs1, in_rs2  input  5  source register addresses
- in_rd  input  5  destination register address
- in_rd_wr  input  1  instruction will write in_rd
- in_imm  input  32  immediate, passed through
- in_ctrl  input  16  opaque execute control, passed through
- rf_addr_rd1, rf_addr_rd2  output  5  register file read addresses (combinational copies of in_rs1/in_rs2)
- rf_data_rd1, rf_data_rd2  input  32  register file read data (combinational, x0 reads 0)
- wb_wr, wb_addr[4:0], wb_data[31:0]  input  writeback port, same signals that drive the register file write port
- out_valid  output  1  operands valid toward execute
- out_ready  input  1  execute accepts
- out_rs1_val, out_rs2_val  output  32  resolved operands
- out_rd  output  5  destination, registered
- out_rd_wr  output  1  write enable, registered
- out_imm  output  32  registered immediate
- out_ctrl  output  16  registered control
- out_illegal  output  1  registered flag: an accessed register is out of range

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0.
  - All busy bits clear.
  - out_* data registers = 0 and out_illegal=0.
  - Reset asserted mid-operation discards the held instruction and all pending busy state immediately.
- Accept condition:
  - fire = in_valid && in_ready.
  - in_ready = (!out_valid || out_ready) && !hazard.
  - in_ready never depends combinationally on in_ready of any other stage.
- Hazard:
  - hazard = (rs1 hit) || (rs2 hit) || (in_rd_wr && rd hit).
  - A hit is when the register is busy, is not x0, and is not being resolved this cycle.
  - "Resolved this cycle" means wb_wr && wb_addr==that register, with bypass enabled (see Optional Feature).
- Operand select:
  - If rs==0, the operand is 0.
  - Else if wb_wr && wb_addr==rs, the operand is wb_data (bypass).
  - Otherwise the operand is rf_data.
  - The selected operand is captured on fire.
- Latency: 1 cycle from fire to out_valid=1.
- Output register:
  - Loads on fire.
  - If out_valid && out_ready && !fire, then out_valid goes to 0.
  - Holds stable while out_valid && !out_ready.
- Scoreboard:
  - Busy bits exist for registers 1..31, or 1..15 when MORE_REGISTERS=0.
  - Set on fire when in_rd_wr && in_rd!=0.
  - Clear on wb_wr for wb_addr.
  - If set and clear hit the same register in the same cycle, set wins. WAW stall guarantees at most one outstanding write per register.
  - wb_addr=0 is ignored.
- Illegal addresses:
  - Applies only when MORE_REGISTERS=0 and bit 4 is set on rs1, rs2, or rd (rd only when in_rd_wr).
  - The instruction is still accepted, with out_illegal=1.
  - Out-of-range operands read as 0.
  - An out-of-range rd does not set busy.
- Back-pressure: out_ready=0 with out_valid=1 forces in_ready=0, independent of hazards.

Optional Feature:
- Macro: OPFETCH_BYPASS_EN.
- Defined:
  - A same-cycle writeback to a busy source or destination resolves the hazard.
  - The operand is taken from wb_data, with no stall.
- Undefined:
  - No forwarding path. A same-cycle writeback does not resolve the hazard.
  - The stall lasts until the cycle after wb_wr, when the busy bit is clear and the register file holds the new value.
  - The operand always comes from rf_data.
  - One extra stall cycle per dependent instruction.

Test Plan:
- Reset, then issue add x5 (rs1=x1 holding 0x11, rs2=x2 holding 0x22, rd=x5) with out_ready=1 -> next cycle out_valid=1, out_rs1_val=0x11, out_rs2_val=0x22, busy[5]=1.
- RAW dependency:
  - Stimulus: after the add above, present rs1=x5; two cycles later pulse wb_wr, wb_addr=5, wb_data=0xABCD.
  - With bypass: in_ready=0 until the wb cycle, then fire with out_rs1_val=0xABCD.
  - Without bypass: fire one cycle later, operand taken from rf_data.
- x0 handling:
  - Stimulus: rs1=0, rs2=0, rd=0, in_rd_wr=1, with wb_wr to addr 0 concurrently.
  - Response: operands 0, no busy bit set, no stall.
- Back-pressure:
  - Stimulus: out_ready=0 for 3 cycles after fire.
  - Response: out_* held stable, in_ready=0.
  - Release out_ready -> next queued instruction fires the same cycle.
- Same-cycle set and clear:
  - Stimulus: wb clears x7 while a new instruction with rd=x7 fires (bypass on).
  - Response: busy[7]=1 afterwards.
- MORE_REGISTERS=0, rs1=x20 -> accepted, out_illegal=1, out_rs1_val=0.
- Async reset mid-stall (busy[3]=1, out_valid=1) -> out_valid=0 and busy clear immediately, without waiting for a clock edge.
